shift_serializer: RTL and testbench

- Parallel-in, serial-out converter built on the team's D flip-flop storage style.
- Accepts a WIDTH-bit word via a valid/ready handshake and emits it one bit per accepted cycle on a serial output.
- The serial output feeds a downstream single-bit register chain (D flip-flop stage) under ser_ready flow control.
- Pulses done when the final bit of a word is accepted.

---
 rtl/shift_serializer_pkg.sv | 19 +
 rtl/shift_serializer_counter.sv | 48 ++++
 rtl/shift_serializer.sv | 118 +++++++++++
 tb/tb_shift_serializer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_serializer_pkg
//  Description : Shared state encoding and default sizing for the
//                parallel-to-serial converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_serializer_pkg;

  // Single-bit state encoding: IDLE waits for a word, SHIFT emits bits.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage : shift_serializer_pkg
`default_nettype wire

// File: rtl/shift_serializer_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter
//  Description : Modulo-MOD up counter with clear priority over enable and
//                a terminal-count flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
  parameter int MOD = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clr,
  output logic [$clog2(MOD)-1:0] count,
  output logic                   at_max
);

  localparam int CW = $clog2(MOD);
  localparam logic [CW-1:0] C_MAX = CW'(MOD - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, terminal count folds back to zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == C_MAX) ? '0 : count_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == C_MAX);

endmodule : mod_counter
`default_nettype wire

// File: rtl/shift_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_serializer
//  Description : Parallel-in, serial-out converter. Accepts a WIDTH-bit word
//                on a valid/ready handshake and emits it one bit per accepted
//                cycle; supports back-to-back words with no idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_serializer
  import shift_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             done_q, done_d;

  logic [CW-1:0]    w_cnt;
  logic             w_cnt_at_max;
  logic             w_cnt_en;
  logic             w_cnt_clr;
  logic             w_accept;
  logic             w_out_bit;
  logic [WIDTH-1:0] w_shifted;

  mod_counter #(
    .MOD (WIDTH)
  ) u_bit_cnt (
    .clk    (clk),
    .reset  (reset),
    .en     (w_cnt_en),
    .clr    (w_cnt_clr),
    .count  (w_cnt),
    .at_max (w_cnt_at_max)
  );

  assign w_accept  = (state_q == ST_SHIFT) && ser_ready;
  assign w_out_bit = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[WIDTH-1];
  assign w_shifted = (LSB_FIRST != 0) ? {1'b0, shreg_q[WIDTH-1:1]}
                                      : {shreg_q[WIDTH-2:0], 1'b0};

  // A new word may enter while idle, or in the cycle the final bit leaves.
  assign load_ready = (state_q == ST_IDLE) || (w_accept && w_cnt_at_max);

  // Next-state, shift and counter control.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
    w_cnt_en  = 1'b0;
    w_cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          shreg_d   = load_data;
          w_cnt_clr = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_accept) begin
          shreg_d  = w_shifted;
          w_cnt_en = 1'b1;
          if (w_cnt == C_LAST) begin
            done_d    = 1'b1;
            w_cnt_clr = 1'b1;
            if (load_valid) begin
              // Back-to-back: the next word's first bit follows immediately.
              shreg_d = load_data;
              state_d = ST_SHIFT;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, shift register and done pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  assign ser_valid = (state_q == ST_SHIFT);
  assign ser_out   = (state_q == ST_SHIFT) ? w_out_bit : 1'b0;
  assign busy      = (state_q == ST_SHIFT);
  assign done      = done_q;

endmodule : shift_serializer
`default_nettype wire

// File: tb/tb_shift_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_serializer
//  Description : Self-checking bench for shift_serializer. Two instances
//                (LSB-first and MSB-first) share clock and reset; a bit-level
//                scoreboard per instance predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_serializer;

  localparam int W = 8;

  typedef struct {
    bit b;
    bit last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         lv [2];
  logic [W-1:0] ld [2];
  logic         sr [2];
  logic         lr [2];
  logic         so [2];
  logic         sv [2];
  logic         bz [2];
  logic         dn [2];

  exp_t q0[$];
  exp_t q1[$];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  shift_serializer #(.WIDTH(W), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .reset(reset),
    .load_valid(lv[0]), .load_ready(lr[0]), .load_data(ld[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .ser_ready(sr[0]),
    .busy(bz[0]), .done(dn[0])
  );

  shift_serializer #(.WIDTH(W), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .reset(reset),
    .load_valid(lv[1]), .load_ready(lr[1]), .load_data(ld[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .ser_ready(sr[1]),
    .busy(bz[1]), .done(dn[1])
  );

  task automatic chk(input logic obs, input logic expv, input string tag);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
    end
  endtask

  // Expected bit stream of one word, in transmission order.
  task automatic push_word(input int d, input logic [W-1:0] data);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b    = (d == 0) ? data[i] : data[W-1-i];
      e.last = (i == W - 1);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  // One clock: check outputs against the model before the edge, update the
  // model for handshakes that complete at the edge, then check done after.
  task automatic tick();
    bit   exp_done [2];
    int   sz;
    bit   exp_lr;
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      sz          = (d == 0) ? q0.size() : q1.size();
      exp_lr      = (sz == 0) || (sz == 1 && sr[d]);
      exp_done[d] = 1'b0;
      chk(lr[d], exp_lr,  $sformatf("load_ready[%0d]", d));
      chk(sv[d], sz != 0, $sformatf("ser_valid[%0d]", d));
      chk(bz[d], sz != 0, $sformatf("busy[%0d]", d));
      if (sz != 0) begin
        e = (d == 0) ? q0[0] : q1[0];
        chk(so[d], e.b, $sformatf("ser_out[%0d]", d));
        if (sr[d]) begin
          if (d == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
          exp_done[d] = e.last;
        end
      end else begin
        chk(so[d], 1'b0, $sformatf("ser_out_idle[%0d]", d));
      end
      if (lv[d] && exp_lr) push_word(d, ld[d]);
    end
    @(posedge clk);
    #1;
    if (reset) begin
      q0.delete();
      q1.delete();
      exp_done[0] = 1'b0;
      exp_done[1] = 1'b0;
    end
    for (int d = 0; d < 2; d++) chk(dn[d], exp_done[d], $sformatf("done[%0d]", d));
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      lv[d] = 1'b0;
      ld[d] = '0;
      sr[d] = 1'b1;
    end

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk(lr[0], 1'b1, "rst_load_ready");
    chk(sv[0], 1'b0, "rst_ser_valid");
    chk(bz[0], 1'b0, "rst_busy");
    chk(dn[0], 1'b0, "rst_done");
    chk(so[0], 1'b0, "rst_ser_out");
    chk(sv[1], 1'b0, "rst_ser_valid_msb");
    tick();

    // Single word LSB first: 8'hA5, data changed during SHIFT is ignored
    lv[0] = 1'b1; ld[0] = 8'hA5;
    tick();
    lv[0] = 1'b0; ld[0] = 8'h00;
    repeat (W) tick();
    chk(sv[0], 1'b0, "single_back_idle");
    tick();

    // Stall on bits 3 and 6 for two cycles each: 12 cycles total
    lv[0] = 1'b1; ld[0] = 8'hA5;
    tick();
    lv[0] = 1'b0;
    begin
      logic [11:0] pat;
      pat = 12'b111001110011; // consumed from bit 11 down
      for (int i = 11; i >= 0; i--) begin
        sr[0] = pat[i];
        tick();
      end
    end
    sr[0] = 1'b1;
    chk(dn[0], 1'b1, "stall_done_after_12");
    chk(sv[0], 1'b0, "stall_idle_after_12");
    tick();

    // Back-to-back: 8'hFF then 8'h00 with no gap, two done pulses
    lv[0] = 1'b1; ld[0] = 8'hFF;
    tick();
    ld[0] = 8'h00;
    repeat (W) tick();
    lv[0] = 1'b0;
    chk(sv[0], 1'b1, "b2b_no_gap");
    repeat (W) tick();
    tick();

    // MSB first: 8'h81, data changed during SHIFT is ignored
    lv[1] = 1'b1; ld[1] = 8'h81;
    tick();
    lv[1] = 1'b0; ld[1] = 8'h7E;
    repeat (W) tick();
    tick();

    // Reset mid-word after 4 bits of 8'h3C, then a clean word
    lv[0] = 1'b1; ld[0] = 8'h3C;
    tick();
    lv[0] = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk(sv[0], 1'b0, "midrst_ser_valid");
    chk(dn[0], 1'b0, "midrst_done");
    chk(lr[0], 1'b1, "midrst_load_ready");
    tick();
    lv[0] = 1'b1; ld[0] = 8'h5A;
    tick();
    lv[0] = 1'b0;
    repeat (W) tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_shift_serializer
`default_nettype wire
